// File: rtl/aliens_march_ctrl.sv
// Step-pulse and sweep-direction controller for the aliens formation.
// Optional kill speed-up is enabled by defining ALIENS_MARCH_SPEEDUP_EN.
//
// state   | meaning
// IDLE    | waiting for the first enable cycle
// MARCH_R | stepping right; a blocked step goes DOWN and reverses
// MARCH_L | stepping left; a blocked step goes DOWN and reverses
// HALT    | defeat or victory seen; frozen until reset
module aliens_march_ctrl #(
  parameter int PERIOD_W     = 24,
  parameter int STEP_PERIOD  = 2500000,
  parameter int MIN_PERIOD   = 4,
  parameter int SPEEDUP_STEP = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                canLeft,
  input  logic                canRight,
  input  logic                defeat,
  input  logic                victory,
  input  logic                killingAlien,
  output logic [1:0]          motion,
  output logic                stepStrobe,
  output logic                halted,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MARCH_R = 2'd1;
  localparam logic [1:0] MARCH_L = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [1:0] MOVE_LEFT  = 2'd1;
  localparam logic [1:0] MOVE_RIGHT = 2'd2;
  localparam logic [1:0] MOVE_DOWN  = 2'd3;

  localparam logic [PERIOD_W-1:0] INIT_PERIOD = PERIOD_W'(STEP_PERIOD);

  logic [1:0]          state;
  logic [PERIOD_W-1:0] cnt;
  logic                marching;
  logic                stopNow;
  logic                stepFire;

  assign marching = (state == MARCH_R) || (state == MARCH_L);
  assign stopNow  = marching && (defeat || victory);
  // Halt has priority, so a step coinciding with defeat/victory never fires.
  assign stepFire = marching && enable && !stopNow && (cnt >= period - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      motion     <= 2'd0;
      stepStrobe <= 1'b0;
      halted     <= 1'b0;
    end else begin
      motion     <= 2'd0;
      stepStrobe <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) state <= MARCH_R;
        end
        MARCH_R, MARCH_L: begin
          if (stopNow) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (stepFire) begin
            cnt        <= '0;
            stepStrobe <= 1'b1;
            if (state == MARCH_R) begin
              if (canRight) begin
                motion <= MOVE_RIGHT;
              end else begin
                motion <= MOVE_DOWN;
                state  <= MARCH_L;
              end
            end else begin
              if (canLeft) begin
                motion <= MOVE_LEFT;
              end else begin
                motion <= MOVE_DOWN;
                state  <= MARCH_R;
              end
            end
          end else if (enable) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALIENS_MARCH_SPEEDUP_EN
  localparam logic [PERIOD_W-1:0] MIN_P        = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_DEC     = PERIOD_W'(SPEEDUP_STEP);
  localparam logic [PERIOD_W-1:0] SHRINK_LIMIT = PERIOD_W'(MIN_PERIOD + SPEEDUP_STEP);

  logic killPrev;
  logic killEdge;

  assign killEdge = killingAlien && !killPrev;

  // The step firing this cycle already compared against the old period.
  always_ff @(posedge clk) begin
    if (reset) begin
      period   <= INIT_PERIOD;
      killPrev <= 1'b0;
    end else begin
      killPrev <= killingAlien;
      if (marching && killEdge)
        period <= (period > SHRINK_LIMIT) ? period - STEP_DEC : MIN_P;
    end
  end
`else
  logic                unusedKill;
  logic [PERIOD_W-1:0] unusedStep;

  assign period     = INIT_PERIOD;
  assign unusedKill = killingAlien;
  assign unusedStep = PERIOD_W'(SPEEDUP_STEP);
`endif

endmodule

// File: tb/tb_aliens_march_ctrl.sv
// Directed bench for aliens_march_ctrl with STEP_PERIOD=8, MIN_PERIOD=4, SPEEDUP_STEP=2.
// Speed-up expectations follow ALIENS_MARCH_SPEEDUP_EN.
module tb_aliens_march_ctrl;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          canLeft = 1'b1;
  logic          canRight = 1'b1;
  logic          defeat = 1'b0;
  logic          victory = 1'b0;
  logic          killingAlien = 1'b0;
  logic [1:0]    motion;
  logic          stepStrobe;
  logic          halted;
  logic [PW-1:0] period;

  int testCount = 0;
  int failCount = 0;

  aliens_march_ctrl #(
    .PERIOD_W(PW), .STEP_PERIOD(8), .MIN_PERIOD(4), .SPEEDUP_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .canLeft(canLeft),
    .canRight(canRight), .defeat(defeat), .victory(victory),
    .killingAlien(killingAlien), .motion(motion), .stepStrobe(stepStrobe),
    .halted(halted), .period(period)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until motion is non-zero; n = maxc+1 on timeout. Also checks strobe tracks motion.
  task automatic waitPulse(input int maxc, output int n, output logic [1:0] m);
    logic strobeOk;
    strobeOk = 1'b1;
    n = maxc + 1;
    m = 2'd0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (stepStrobe !== (motion != 2'd0)) strobeOk = 1'b0;
      if (motion != 2'd0) begin
        n = i;
        m = motion;
        break;
      end
    end
    check("strobe_follows_motion", 32'(strobeOk), 32'd1);
  endtask

  task automatic expectPulse(input string tag, input int pre, input int expN, input logic [1:0] expM);
    int n;
    logic [1:0] m;
    waitPulse(40, n, m);
    check({tag, "_spacing"}, 32'(pre + n), 32'(expN));
    check({tag, "_motion"}, 32'(m), 32'(expM));
  endtask

  initial begin
    int p1, p2, p3;
    logic quiet;
`ifdef ALIENS_MARCH_SPEEDUP_EN
    p1 = 6; p2 = 4; p3 = 4;
`else
    p1 = 8; p2 = 8; p3 = 8;
`endif

    tick(); tick();
    check("reset_motion", 32'(motion), 32'd0);
    check("reset_strobe", 32'(stepStrobe), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_period", 32'(period), 32'd8);

    // first pulse: one IDLE cycle plus a full 8-cycle window
    reset = 1'b0; enable = 1'b1;
    expectPulse("first_right", 0, 9, 2'd2);
    tick();
    check("pulse_one_cycle", 32'(motion), 32'd0);
    expectPulse("second_right", 1, 8, 2'd2);

    // right edge reached: DOWN then left sweep, then left edge: DOWN then right
    canRight = 1'b0;
    expectPulse("down_at_right", 0, 8, 2'd3);
    canRight = 1'b1;
    expectPulse("march_left", 0, 8, 2'd1);
    canLeft = 1'b0;
    expectPulse("down_at_left", 0, 8, 2'd3);
    canLeft = 1'b1;
    expectPulse("back_right", 0, 8, 2'd2);

    // kills at window start; the first kill is a 5-cycle level
    killingAlien = 1'b1;
    repeat (5) tick();
    killingAlien = 1'b0;
    check("period_kill1", 32'(period), 32'(p1));
    expectPulse("kill1", 5, p1, 2'd2);
    killingAlien = 1'b1; tick(); killingAlien = 1'b0;
    check("period_kill2", 32'(period), 32'(p2));
    expectPulse("kill2", 1, p2, 2'd2);
    killingAlien = 1'b1; tick(); killingAlien = 1'b0;
    check("period_kill3_floor", 32'(period), 32'(p3));
    expectPulse("kill3", 1, p3, 2'd2);

    // pause at cnt=3 for 5 cycles
    repeat (3) tick();
    enable = 1'b0;
    quiet = 1'b1;
    repeat (5) begin
      tick();
      if (motion != 2'd0) quiet = 1'b0;
    end
    check("pause_no_motion", 32'(quiet), 32'd1);
    enable = 1'b1;
    expectPulse("after_pause", 8, p3 + 5, 2'd2);

    // defeat mid-window
    repeat (2) tick();
    defeat = 1'b1; tick(); defeat = 1'b0;
    check("defeat_halted", 32'(halted), 32'd1);
    check("defeat_motion", 32'(motion), 32'd0);
    quiet = 1'b1;
    repeat (100) begin
      tick();
      if (motion != 2'd0 || stepStrobe != 1'b0 || halted != 1'b1) quiet = 1'b0;
    end
    check("halt_quiet_100", 32'(quiet), 32'd1);

    reset = 1'b1; tick(); reset = 1'b0;
    check("rehalt_reset_halted", 32'(halted), 32'd0);
    check("rehalt_reset_period", 32'(period), 32'd8);
    expectPulse("restart", 0, 9, 2'd2);

    // victory in the very cycle a step would fire
    repeat (7) tick();
    victory = 1'b1; tick(); victory = 1'b0;
    check("victory_beats_step_motion", 32'(motion), 32'd0);
    check("victory_halted", 32'(halted), 32'd1);
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (motion != 2'd0) quiet = 1'b0;
    end
    check("victory_quiet", 32'(quiet), 32'd1);

    // reset in the cycle a step would fire
    reset = 1'b1; tick(); reset = 1'b0;
    expectPulse("pre_reset_run", 0, 9, 2'd2);
    repeat (7) tick();
    reset = 1'b1; tick();
    check("reset_drop_pulse", 32'(motion), 32'd0);
    check("reset_drop_strobe", 32'(stepStrobe), 32'd0);
    check("reset_drop_period", 32'(period), 32'd8);
    check("reset_drop_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    expectPulse("from_idle_again", 0, 9, 2'd2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
